// File: rtl/npc_pkg.sv
// Shared constants and FSM encoding for the instruction fetch front end.
package npc_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fq_state_e;

endpackage

// File: rtl/fq_ram.sv
// Fetch-queue storage: DEPTH entries of {pc, instr, filled} with alloc/fill/head pointers.
module fq_ram
    import npc_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_rstn,
    input  logic            i_flush,
    input  logic            i_alloc_en,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_fill_en,
    input  logic [31:0]     i_fill_instr,
    input  logic            i_pop_en,
    output logic [XLEN-1:0] o_head_pc,
    output logic [31:0]     o_head_instr,
    output logic            o_head_filled,
    output logic [AW:0]     o_count,
    output logic [AW:0]     o_unfilled
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [AW:0]      r_alloc_ptr;
    logic [AW:0]      r_fill_ptr;
    logic [AW:0]      r_head_ptr;

    wire [AW-1:0] w_alloc_idx = r_alloc_ptr[AW-1:0];
    wire [AW-1:0] w_fill_idx  = r_fill_ptr[AW-1:0];
    wire [AW-1:0] w_head_idx  = r_head_ptr[AW-1:0];

    // Fill always targets an unfilled slot and pop a filled one, so they never collide.
    always_ff @(posedge clk) begin
        if (!i_rstn || i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_filled    <= '0;
        end else begin
            if (i_alloc_en) begin
                r_alloc_ptr <= r_alloc_ptr + PTR_ONE;
            end
            if (i_fill_en) begin
                r_filled[w_fill_idx] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PTR_ONE;
            end
            if (i_pop_en) begin
                r_filled[w_head_idx] <= 1'b0;
                r_head_ptr           <= r_head_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_alloc_en) begin
            r_pc_mem[w_alloc_idx] <= i_alloc_pc;
        end
        if (i_fill_en) begin
            r_instr_mem[w_fill_idx] <= i_fill_instr;
        end
    end

    assign o_head_pc     = r_pc_mem[w_head_idx];
    assign o_head_instr  = r_instr_mem[w_head_idx];
    assign o_head_filled = r_filled[w_head_idx];
    assign o_count       = r_alloc_ptr - r_head_ptr;
    assign o_unfilled    = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: pc generation, in-order fetch queue to decode, and
// redirect handling that drains responses still in flight for discarded requests.
module ifu_fetch_queue
    import npc_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_snxt_pc
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    fq_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic [AW:0]     r_drop_cnt;

    logic [XLEN-1:0] w_head_pc;
    logic [31:0]     w_head_instr;
    logic            w_head_filled;
    logic [AW:0]     w_count;
    logic [AW:0]     w_unfilled;

    wire w_in_fetch  = (r_state == FETCH);
    wire w_req_valid = rstn && w_in_fetch && (w_count < DEPTH_C) && !redirect_en;
    wire w_req_fire  = w_req_valid && imem_req_ready;
    wire w_fill      = rstn && w_in_fetch && !redirect_en && imem_rsp_valid && (w_unfilled != '0);
    wire w_out_valid = rstn && w_head_filled && !redirect_en;
    wire w_out_fire  = w_out_valid && out_ready;

    // A response arriving in the redirect cycle itself is already accounted for.
    wire [AW:0] w_fetch_drop = (imem_rsp_valid && w_unfilled != '0) ? w_unfilled - CNT_ONE : w_unfilled;
    wire [AW:0] w_drain_drop = (imem_rsp_valid && r_drop_cnt != '0) ? r_drop_cnt - CNT_ONE : r_drop_cnt;
    wire [AW:0] w_outstanding = w_in_fetch ? w_unfilled : r_drop_cnt;

    fq_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fq_ram (
        .clk           (clk),
        .i_rstn        (rstn),
        .i_flush       (redirect_en),
        .i_alloc_en    (w_req_fire),
        .i_alloc_pc    (r_pc),
        .i_fill_en     (w_fill),
        .i_fill_instr  (imem_rsp_instr),
        .i_pop_en      (w_out_fire),
        .o_head_pc     (w_head_pc),
        .o_head_instr  (w_head_instr),
        .o_head_filled (w_head_filled),
        .o_count       (w_count),
        .o_unfilled    (w_unfilled)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc       <= RESET_PC;
            r_state    <= FETCH;
            r_drop_cnt <= '0;
        end else begin
            if (redirect_en) begin
                r_pc <= redirect_pc;
            end else if (w_req_fire) begin
                r_pc <= r_pc + XLEN'(4);
            end
            case (r_state)
                FETCH: begin
                    if (redirect_en) begin
                        r_drop_cnt <= w_fetch_drop;
                        r_state    <= (w_fetch_drop != '0) ? DRAIN : FETCH;
                    end
                end
                DRAIN: begin
                    r_drop_cnt <= w_drain_drop;
                    if (!redirect_en && w_drain_drop == '0) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign out_valid      = w_out_valid;
    assign out_pc         = rstn ? w_head_pc : '0;
    assign out_instr      = rstn ? w_head_instr : '0;
    assign out_snxt_pc    = rstn ? w_head_pc + XLEN'(4) : '0;

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rstn)
        imem_rsp_valid |-> (w_outstanding != '0));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with a 1-cycle in-order memory model.
module tb_ifu_fetch_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_snxt_pc;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] pend[$];
    bit          mem_en;

    always #5 clk = ~clk;

    ifu_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h8000_0000)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_snxt_pc    (out_snxt_pc)
    );

    function automatic logic [31:0] mk(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: capture request fire before the edge, then present the next response.
    task automatic step();
        logic        f;
        logic [63:0] a;
        @(negedge clk);
        f = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        @(posedge clk);
        #1;
        if (!rstn) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            if (f) pend.push_back(a);
            if (mem_en && pend.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_instr = mk(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic wait_req(input string tag, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (imem_req_valid) ok = 1'b1;
            else begin
                check({tag, "_no_out"}, 64'(out_valid), 64'd0);
                step();
            end
        end
        check({tag, "_req_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_pc"}, out_pc, 64'd0);
        check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
        check({tag, "_out_snxt"}, out_snxt_pc, 64'd0);
    endtask

    initial begin
        rstn = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_instr = '0;
        out_ready = 1'b0; mem_en = 1'b1;
        step(); step();
        check_reset_outs("rst");

        // Reset release and first fetches
        rstn = 1'b1; #1;
        check("first_req_valid", 64'(imem_req_valid), 64'd1);
        check("first_req_addr", imem_req_addr, 64'h8000_0000);
        check("first_no_out", 64'(out_valid), 64'd0);
        step();
        check("second_req_addr", imem_req_addr, 64'h8000_0004);
        check("second_no_out", 64'(out_valid), 64'd0);
        step();
        check("first_out_valid", 64'(out_valid), 64'd1);
        check("first_out_pc", out_pc, 64'h8000_0000);
        check("first_out_instr", 64'(out_instr), 64'(mk(64'h8000_0000)));
        check("first_out_snxt", out_snxt_pc, 64'h8000_0004);
        check("third_req_addr", imem_req_addr, 64'h8000_0008);
        step();
        check("fourth_req_addr", imem_req_addr, 64'h8000_000C);

        // Backpressure: queue full after four requests
        step();
        check("full_req_off", 64'(imem_req_valid), 64'd0);
        step(); step();
        check("full_req_still_off", 64'(imem_req_valid), 64'd0);
        check("full_head_pc", out_pc, 64'h8000_0000);
        out_ready = 1'b1; #1;
        check("pop_cycle_no_req", 64'(imem_req_valid), 64'd0);
        step();
        out_ready = 1'b0; #1;
        check("after_pop_req", 64'(imem_req_valid), 64'd1);
        check("after_pop_addr", imem_req_addr, 64'h8000_0010);
        check("after_pop_head_pc", out_pc, 64'h8000_0004);
        check("after_pop_head_instr", 64'(out_instr), 64'(mk(64'h8000_0004)));
        step();
        check("refull_req_off", 64'(imem_req_valid), 64'd0);
        step(); step();

        // Clean redirect with nothing outstanding; out_ready ignored
        redirect_en = 1'b1; redirect_pc = 64'h8000_1000; out_ready = 1'b1; #1;
        check("redir_out_masked", 64'(out_valid), 64'd0);
        check("redir_req_off", 64'(imem_req_valid), 64'd0);
        step();
        redirect_en = 1'b0; out_ready = 1'b0; #1;
        check("clean_queue_empty", 64'(out_valid), 64'd0);
        check("clean_req_valid", 64'(imem_req_valid), 64'd1);
        check("clean_req_addr", imem_req_addr, 64'h8000_1000);

        // Stale drain: three outstanding, one response in the redirect cycle
        mem_en = 1'b0;
        step(); step(); step();
        imem_req_ready = 1'b0;
        check("three_out_addr", imem_req_addr, 64'h8000_100C);
        imem_rsp_valid = 1'b1; imem_rsp_instr = mk(pend.pop_front());
        redirect_en = 1'b1; redirect_pc = 64'h8000_2000; mem_en = 1'b1; #1;
        check("stale_redir_out", 64'(out_valid), 64'd0);
        check("stale_redir_req", 64'(imem_req_valid), 64'd0);
        step();
        imem_req_ready = 1'b1; redirect_en = 1'b0; #1;
        check("drain_req_off", 64'(imem_req_valid), 64'd0);
        check("drain_out_off", 64'(out_valid), 64'd0);
        wait_req("drain1", 5);
        check("post_drain_addr", imem_req_addr, 64'h8000_2000);
        step();
        check("post_drain_no_out", 64'(out_valid), 64'd0);
        step();
        check("post_drain_out_valid", 64'(out_valid), 64'd1);
        check("post_drain_out_pc", out_pc, 64'h8000_2000);
        check("post_drain_out_instr", 64'(out_instr), 64'(mk(64'h8000_2000)));

        // Double redirect: second redirect lands while draining
        imem_req_ready = 1'b0;
        step();
        mem_en = 1'b0; imem_req_ready = 1'b1;
        step(); step();
        check("dbl_full_req_off", 64'(imem_req_valid), 64'd0);
        redirect_en = 1'b1; redirect_pc = 64'h8000_4000; #1;
        check("dbl_redir1_out_masked", 64'(out_valid), 64'd0);
        step();
        redirect_en = 1'b0; #1;
        check("dbl_drain_req_off", 64'(imem_req_valid), 64'd0);
        redirect_en = 1'b1; redirect_pc = 64'h8000_3000; #1;
        check("dbl_redir2_req_off", 64'(imem_req_valid), 64'd0);
        mem_en = 1'b1;
        step();
        redirect_en = 1'b0; #1;
        wait_req("drain2", 6);
        check("dbl_post_addr", imem_req_addr, 64'h8000_3000);
        step(); step();
        check("dbl_out_valid", 64'(out_valid), 64'd1);
        check("dbl_out_pc", out_pc, 64'h8000_3000);
        check("dbl_out_instr", 64'(out_instr), 64'(mk(64'h8000_3000)));

        // Reset mid-flight with the queue full
        mem_en = 1'b0;
        for (int i = 0; i < 8 && imem_req_valid; i++) step();
        check("midrst_queue_full", 64'(imem_req_valid), 64'd0);
        rstn = 1'b0; imem_rsp_valid = 1'b0;
        step();
        check_reset_outs("midrst");
        rstn = 1'b1; mem_en = 1'b1; #1;
        check("midrst_req_valid", 64'(imem_req_valid), 64'd1);
        check("midrst_req_addr", imem_req_addr, 64'h8000_0000);
        check("midrst_no_out", 64'(out_valid), 64'd0);
        step();
        check("midrst_queue_cleared", 64'(out_valid), 64'd0);
        step();
        check("midrst_out_valid", 64'(out_valid), 64'd1);
        check("midrst_out_pc", out_pc, 64'h8000_0000);
        check("midrst_out_instr", 64'(out_instr), 64'(mk(64'h8000_0000)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
